// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit ALU with a valid/ready response path.
// Optional feature: define ALU_ARB_OPCHECK_EN to answer op 111 with result 0, zero 1, err 1.

module alu (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero_bit
);

  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = a & b;
      3'b001:  result = a | b;
      3'b010:  result = a ^ b;
      3'b011:  result = ~(a | b);
      3'b100:  result = {31'd0, ($signed(a) < $signed(b))};
      3'b101:  result = a + b;
      3'b110:  result = a - b;
      default: result = '0;
    endcase
  end

  assign zero_bit = (result == 32'd0);

endmodule

// state | meaning
// IDLE  | no operation outstanding; grant the round-robin winner
// EXEC  | ALU evaluates the latched op/a/b
// RESP  | response held to the owner until it is consumed
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        prio;
  logic        owner;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] res_q;
  logic        zero_q, err_q;

  logic        winner, accept, done;
  logic [31:0] alu_result;
  logic        zero_bit;
  logic [31:0] res_d;
  logic        zero_d, err_d;

  alu u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .zero_bit (zero_bit)
  );

  // Priority only matters when both requesters are valid.
  assign winner = req1_valid && (!req0_valid || prio);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if ((req0_valid || req1_valid) && !rst) begin
          accept     = 1'b1;
          req0_ready = !winner;
          req1_ready = winner;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        done = owner ? rsp1_ready : rsp0_ready;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_ARB_OPCHECK_EN
  always_comb begin
    res_d  = alu_result;
    zero_d = zero_bit;
    err_d  = 1'b0;
    if (op_q == 3'b111) begin
      res_d  = '0;
      zero_d = 1'b1;
      err_d  = 1'b1;
    end
  end
`else
  assign res_d  = alu_result;
  assign zero_d = zero_bit;
  assign err_d  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= RR_INIT;
      owner  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= winner;
        op_q  <= winner ? req1_op : req0_op;
        a_q   <= winner ? req1_a  : req0_a;
        b_q   <= winner ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        res_q  <= res_d;
        zero_q <= zero_d;
        err_q  <= err_d;
      end
      if (done) prio <= !owner;
    end
  end

  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) && owner;
  assign rsp0_result = rsp0_valid ? res_q : '0;
  assign rsp1_result = rsp1_valid ? res_q : '0;
  assign rsp0_zero   = rsp0_valid && zero_q;
  assign rsp1_zero   = rsp1_valid && zero_q;
  assign rsp0_err    = rsp0_valid && err_q;
  assign rsp1_err    = rsp1_valid && err_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases with literal results, then randomized traffic
// compared every cycle against a transaction-level model.
module tb_alu_arbiter;

  localparam bit RR_INIT = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err, busy;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_err(rsp1_err),
    .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: one outstanding operation, described by its age in cycles since acceptance.
  bit          m_busy  = 1'b0;
  int          m_age   = 0;
  bit          m_owner = 1'b0;
  bit          m_prio  = RR_INIT;
  logic [31:0] m_res   = '0;
  bit          m_zero, m_err, m_undef;

  bit          smp_rdy[2], smp_v[2], smp_zero[2], smp_err[2], smp_busy;
  logic [31:0] smp_res[2];

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return a + b;
      3'd6: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, predicts the coming edge, returns at next posedge+1.
  task automatic step();
    bit          rv0, rv1, w, rr;
    bit          er[2], ev[2], ez[2], ee[2];
    logic [31:0] eres[2];
    logic [2:0]  op;
    logic [31:0] a, b;
    #3;
    cyc++;
    rv0 = req0_valid;
    rv1 = req1_valid;
    w   = (rv0 && rv1) ? m_prio : rv1;
    for (int n = 0; n < 2; n++) begin
      er[n]   = !rst && !m_busy && (rv0 || rv1) && (w == n);
      ev[n]   = !rst && m_busy && (m_age >= 2) && (m_owner == n);
      eres[n] = ev[n] ? m_res : 32'd0;
      ez[n]   = ev[n] && m_zero;
      ee[n]   = ev[n] && m_err;
    end
    smp_rdy[0] = req0_ready;  smp_rdy[1] = req1_ready;
    smp_v[0]   = rsp0_valid;  smp_v[1]   = rsp1_valid;
    smp_res[0] = rsp0_result; smp_res[1] = rsp1_result;
    smp_zero[0] = rsp0_zero;  smp_zero[1] = rsp1_zero;
    smp_err[0] = rsp0_err;    smp_err[1] = rsp1_err;
    smp_busy   = busy;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("req%0d_ready", n), smp_rdy[n], er[n]);
      chk($sformatf("rsp%0d_valid", n), smp_v[n], ev[n]);
      if (!(ev[n] && m_undef)) begin
        chk($sformatf("rsp%0d_result", n), smp_res[n], eres[n]);
        chk($sformatf("rsp%0d_zero", n), smp_zero[n], ez[n]);
      end
      chk($sformatf("rsp%0d_err", n), smp_err[n], ee[n]);
    end
    chk("busy", smp_busy, !rst && m_busy);

    rr = m_owner ? rsp1_ready : rsp0_ready;
    if (rst) begin
      m_busy = 1'b0;
      m_prio = RR_INIT;
      m_age  = 0;
    end else if (!m_busy) begin
      if (rv0 || rv1) begin
        op = w ? req1_op : req0_op;
        a  = w ? req1_a  : req0_a;
        b  = w ? req1_b  : req0_b;
        m_owner = w;
        m_busy  = 1'b1;
        m_age   = 1;
        m_res   = alu_ref(op, a, b);
        m_err   = 1'b0;
        m_undef = 1'b0;
        if (op == 3'b111) begin
`ifdef ALU_ARB_OPCHECK_EN
          m_res = 32'd0;
          m_err = 1'b1;
`else
          m_undef = 1'b1;
`endif
        end
        m_zero = (m_res == 32'd0);
      end
    end else if (m_age >= 2) begin
      if (rr) begin
        m_busy = 1'b0;
        m_prio = !m_owner;
      end
    end else begin
      m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic drop(input int n);
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int n, output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (smp_rdy[n]) begin
        t = cyc;
        drop(n);
        return;
      end
    end
    chk($sformatf("req%0d_accept_wait", n), smp_rdy[n], 1);
  endtask

  task automatic wait_rsp(input int n, input int t_acc, input int hold,
                          input logic [31:0] lres, input bit lzero, input bit lerr);
    int tv = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (smp_v[n]) begin
        tv = cyc;
        break;
      end
    end
    chk($sformatf("rsp%0d_latency", n), tv - t_acc, 2);
    chk($sformatf("rsp%0d_lit_result", n), smp_res[n], lres);
    chk($sformatf("rsp%0d_lit_zero", n), smp_zero[n], lzero);
    chk($sformatf("rsp%0d_lit_err", n), smp_err[n], lerr);
    repeat (hold) step();
    if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    // Reset state, then a single ADD.
    reset_dut();
    set_req(0, 1, 3'd5, 32'd5, 32'd7);
    wait_ready(0, t);
    wait_rsp(0, t, 0, 32'd12, 1'b0, 1'b0);

    // Simultaneous requests: priority order, then re-presented req0 loses to waiting req1.
    reset_dut();
    set_req(0, 1, 3'd6, 32'd9, 32'd9);
    set_req(1, 1, 3'd1, 32'h0000_00F0, 32'h0000_000F);
    step();
    chk("both_r0_wins", smp_rdy[0], 1);
    chk("both_r1_waits", smp_rdy[1], 0);
    t = cyc;
    drop(0);
    wait_rsp(0, t, 0, 32'd0, 1'b1, 1'b0);
    set_req(0, 1, 3'd6, 32'd9, 32'd9);
    step();
    chk("repeat_r1_wins", smp_rdy[1], 1);
    chk("repeat_r0_waits", smp_rdy[0], 0);
    t = cyc;
    drop(1);
    wait_rsp(1, t, 0, 32'h0000_00FF, 1'b0, 1'b0);
    wait_ready(0, t);
    wait_rsp(0, t, 0, 32'd0, 1'b1, 1'b0);

    // Signed SLT under back-pressure while req0 waits.
    reset_dut();
    set_req(1, 1, 3'd4, 32'hFFFF_FFFF, 32'd1);
    wait_ready(1, t);
    set_req(0, 1, 3'd5, 32'd1, 32'd2);
    wait_rsp(1, t, 5, 32'd1, 1'b0, 1'b0);
    step();
    chk("req0_after_handshake", smp_rdy[0], 1);
    t = cyc;
    drop(0);
    wait_rsp(0, t, 0, 32'd3, 1'b0, 1'b0);

    // Back-to-back req0 ops; three solo completions leave priority with req1.
    reset_dut();
    set_req(0, 1, 3'd3, 32'd0, 32'd0);
    wait_ready(0, t);
    wait_rsp(0, t, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    set_req(0, 1, 3'd0, 32'hFFFF_0000, 32'h0000_FFFF);
    wait_ready(0, t);
    wait_rsp(0, t, 0, 32'd0, 1'b1, 1'b0);
    set_req(0, 1, 3'd2, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wait_ready(0, t);
    wait_rsp(0, t, 0, 32'h5A5A_5A5A, 1'b0, 1'b0);
    set_req(0, 1, 3'd6, 32'd3, 32'd5);
    set_req(1, 1, 3'd5, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("alternate_r1_wins", smp_rdy[1], 1);
    t = cyc;
    drop(1);
    wait_rsp(1, t, 0, 32'd0, 1'b1, 1'b0);
    wait_ready(0, t);
    wait_rsp(0, t, 0, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Reset during EXEC discards the operation.
    reset_dut();
    set_req(1, 1, 3'd5, 32'd1, 32'd1);
    step();
    t = cyc;
    drop(1);
    set_req(0, 1, 3'd5, 32'd100, 32'd200);
    rst = 1'b1;
    step();
    chk("midop_busy", smp_busy, 0);
    chk("midop_ready0", smp_rdy[0], 0);
    chk("midop_valid1", smp_v[1], 0);
    rst = 1'b0;
    drop(0);
    repeat (4) step();
    set_req(0, 1, 3'd5, 32'd100, 32'd200);
    set_req(1, 1, 3'd1, 32'd0, 32'd0);
    step();
    chk("post_reset_r0_wins", smp_rdy[0], 1);
    t = cyc;
    drop(0);
    wait_rsp(0, t, 0, 32'd300, 1'b0, 1'b0);
    wait_ready(1, t);
    wait_rsp(1, t, 0, 32'd0, 1'b1, 1'b0);

`ifdef ALU_ARB_OPCHECK_EN
    reset_dut();
    set_req(0, 1, 3'd7, 32'd3, 32'd4);
    wait_ready(0, t);
    wait_rsp(0, t, 0, 32'd0, 1'b1, 1'b1);
`endif

    // Randomized traffic; requesters hold their request until accepted.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      for (int n = 0; n < 2; n++) begin
        if (!(n == 0 ? req0_valid : req1_valid) && $urandom_range(0, 3) == 0) begin
          op = 3'($urandom_range(0, 7));
          if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd5;
          set_req(n, 1, op, pick(), pick());
        end
      end
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
      for (int n = 0; n < 2; n++) if (smp_rdy[n]) drop(n);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
